riscv_lsu: RTL

Load/store unit sitting between the decoder/ALU stage and data memory. It is the upstream producer of the load value written back into the register file.
- Accepts one memory request per instruction from the core.
- Drives a word-addressed memory with byte enables and stalls the core until the memory acknowledges.
- Returns byte/half/word load data sign- or zero-extended and aligned to bit 0, ready for the register-file write port.

---
 rtl/riscv_lsu_if.sv | 39 +++
 rtl/riscv_lsu.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_if.sv
// Core/memory bundle for the load/store unit.
// slave: LSU side (core request in, memory bus out); master: the surroundings.
interface riscv_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              core_req_i;
  logic              core_we_i;
  logic [2:0]        core_size_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [31:0]       core_wd_i;
  logic [31:0]       core_rd_o;
  logic              core_stall_o;
  logic              misalign_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wd_o;
  logic [31:0]       mem_rd_i;
  logic              mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i,
    input  core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, misalign_o,
    output mem_req_o, mem_we_o, mem_be_o,
    output mem_addr_o, mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i,
    output core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, misalign_o,
    input  mem_req_o, mem_we_o, mem_be_o,
    input  mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: one word-addressed memory access per core request.
// Ports: clk_i, rst_i (async, active-high), bus (riscv_lsu_if.slave).
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip memory, flag misalign_o.
module riscv_lsu #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RD_RESET = 32'h0000_0000
) (
  input logic        clk_i,
  input logic        rst_i,
  riscv_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    K_B,
    K_H,
    K_W
  } kind_t;

  state_t            state;
  logic [2:0]        size_q;
  logic [1:0]        lo_q;
  logic [31:0]       rd_q;
  logic              req_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q;
  logic              mis_q;

  kind_t             k_in;
  logic [1:0]        lo_in;
  logic              mis;

  // Sizes 3/6/7 fall into the word case.
  function automatic kind_t kind_of(input logic [2:0] sz);
    unique case (sz)
      3'd0, 3'd4: kind_of = K_B;
      3'd1, 3'd5: kind_of = K_H;
      default:    kind_of = K_W;
    endcase
  endfunction

  function automatic logic [3:0] st_be(input kind_t k, input logic [1:0] lo);
    unique case (k)
      K_B:     st_be = 4'b0001 << lo;
      K_H:     st_be = lo[1] ? 4'b1100 : 4'b0011;
      default: st_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_wd(input kind_t k, input logic [31:0] d);
    unique case (k)
      K_B:     st_wd = {4{d[7:0]}};
      K_H:     st_wd = {2{d[15:0]}};
      default: st_wd = d;
    endcase
  endfunction

  // Sizes 0/1 sign-extend, 4/5 zero-extend (size bit 2 = unsigned).
  function automatic logic [31:0] ld_ext(
    input logic [2:0]  sz,
    input logic [1:0]  lo,
    input logic [31:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;
    b  = 8'(w >> {lo, 3'b000});
    h  = lo[1] ? w[31:16] : w[15:0];
    sx = !sz[2];
    unique case (kind_of(sz))
      K_B:     ld_ext = {{24{sx & b[7]}}, b};
      K_H:     ld_ext = {{16{sx & h[15]}}, h};
      default: ld_ext = w;
    endcase
  endfunction

  assign k_in  = kind_of(bus.core_size_i);
  assign lo_in = bus.core_addr_i[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (k_in == K_H && lo_in[0]) ||
               (k_in == K_W && lo_in != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      size_q <= '0;
      lo_q   <= '0;
      rd_q   <= RD_RESET;
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      be_q   <= '0;
      addr_q <= '0;
      wd_q   <= '0;
      mis_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.core_req_i) begin
            size_q <= bus.core_size_i;
            lo_q   <= lo_in;
            if (mis) begin
              state <= DONE;
              mis_q <= 1'b1;
            end else begin
              state  <= BUSY;
              req_q  <= 1'b1;
              we_q   <= bus.core_we_i;
              be_q   <= bus.core_we_i ? st_be(k_in, lo_in)
                                      : 4'b1111;
              addr_q <= {bus.core_addr_i[ADDR_W-1:2], 2'b00};
              wd_q   <= st_wd(k_in, bus.core_wd_i);
            end
          end
        end
        BUSY: begin
          if (bus.mem_ready_i) begin
            if (!we_q) begin
              rd_q <= ld_ext(size_q, lo_q, bus.mem_rd_i);
            end
            state <= DONE;
            req_q <= 1'b0;
            we_q  <= 1'b0;
            be_q  <= '0;
          end
        end
        DONE: begin
          // Core has one cycle to move on; a held request is not re-taken here.
          state <= IDLE;
          mis_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_stall_o = !rst_i &&
    ((state == IDLE && bus.core_req_i) || state == BUSY);
  assign bus.core_rd_o  = rd_q;
  assign bus.misalign_o = mis_q;
  assign bus.mem_req_o  = req_q;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_be_o   = be_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_wd_o   = wd_q;

endmodule
